// File: rtl/delay_index_controller_pkg.sv
// Shared sizing constants and FSM encoding for the delay index controller.
// CFG_PARITY_EN adds a trailing even-parity bit to each configuration frame.
package delay_index_controller_pkg;

  localparam int BUFFER_SIZE        = 16;
  localparam int NUMBER_OF_CHANNELS = 3;
  localparam int NUM_SLOTS          = 2 * NUMBER_OF_CHANNELS;
  localparam int SEL_W              = 3;

`ifdef CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/delay_index_controller_cfg_frame_shifter.sv
// Serial config frame capture: shift register, saturating bit counter, frame check.
// With CFG_PARITY_EN the last bit is even parity over select and index.
module cfg_frame_shifter #(
  parameter int SEL_W = 3,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             shift,
  input  logic             bit_valid,
  input  logic             data_bit,
  output logic [SEL_W-1:0] sel,
  output logic [IDX_W-1:0] idx,
  output logic             frame_ok
);
  import delay_index_controller_pkg::*;

  localparam int FRAME_LEN = SEL_W + IDX_W + PAR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  logic [FRAME_LEN-1:0] sreg;
  logic [CNT_W-1:0]     count;

  // A frame opens with a cleared register; a bit valid in the opening cycle is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      count <= '0;
    end else if (start) begin
      sreg  <= FRAME_LEN'(bit_valid & data_bit);
      count <= CNT_W'(bit_valid);
    end else if (shift) begin
      sreg <= {sreg[FRAME_LEN-2:0], data_bit};
      if (count != CNT_W'(FRAME_LEN + 1)) begin
        count <= count + 1'b1;
      end
    end
  end

  assign sel = sreg[FRAME_LEN-1 -: SEL_W];
  assign idx = sreg[PAR_W +: IDX_W];

`ifdef CFG_PARITY_EN
  assign frame_ok = (count == CNT_W'(FRAME_LEN)) && !(^sreg);
`else
  assign frame_ok = (count == CNT_W'(FRAME_LEN));
`endif

endmodule

// File: rtl/delay_index_controller.sv
// Shadowed delay index registers loaded by serial frames, committed atomically on ws falling edges.
// CFG_PARITY_EN (see package) enables frame parity checking in cfg_frame_shifter.
module delay_index_controller #(
  parameter int NUM_SLOTS   = delay_index_controller_pkg::NUM_SLOTS,
  parameter int BUFFER_SIZE = delay_index_controller_pkg::BUFFER_SIZE,
  parameter int SEL_W       = delay_index_controller_pkg::SEL_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      ws,
  input  logic                                      cfg_frame,
  input  logic                                      cfg_bit_valid,
  input  logic                                      cfg_bit,
  output logic [NUM_SLOTS*$clog2(BUFFER_SIZE)-1:0]  delay_index,
  output logic                                      cfg_busy,
  output logic                                      cfg_error,
  output logic                                      commit
);
  import delay_index_controller_pkg::*;

  localparam int IDX_W = $clog2(BUFFER_SIZE);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] frame_sel;
  logic [IDX_W-1:0] frame_idx;
  logic             frame_ok;
  logic             write_ok;
  logic             pending;
  logic             ws_q;
  logic             commit_now;
  logic [IDX_W-1:0] shadow [NUM_SLOTS];

  cfg_frame_shifter #(
    .SEL_W (SEL_W),
    .IDX_W (IDX_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     ((state == IDLE) && cfg_frame),
    .shift     ((state == SHIFT) && cfg_bit_valid),
    .bit_valid (cfg_bit_valid),
    .data_bit  (cfg_bit),
    .sel       (frame_sel),
    .idx       (frame_idx),
    .frame_ok  (frame_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    write_ok  = 1'b0;
    cfg_error = 1'b0;
    case (state)
      IDLE:  if (cfg_frame) state_nxt = SHIFT;
      SHIFT: if (!cfg_frame) state_nxt = WRITE;
      WRITE: begin
        state_nxt = IDLE;
        write_ok  = frame_ok && (int'(frame_sel) < NUM_SLOTS);
        cfg_error = !write_ok;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign commit_now = ws_q && !ws && pending;
  assign cfg_busy   = (state != IDLE) || pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow[k] <= '0;
      end
    end else if (write_ok) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (frame_sel == SEL_W'(k)) begin
          shadow[k] <= frame_idx;
        end
      end
    end
  end

  // A commit in the WRITE cycle captures the old shadow; the new write stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q        <= 1'b0;
      pending     <= 1'b0;
      commit      <= 1'b0;
      delay_index <= '0;
    end else begin
      ws_q   <= ws;
      commit <= commit_now;
      if (write_ok) begin
        pending <= 1'b1;
      end else if (commit_now) begin
        pending <= 1'b0;
      end
      if (commit_now) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          delay_index[k*IDX_W +: IDX_W] <= shadow[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_index_controller.sv
// Randomized bench for delay_index_controller against a slot-array reference model.
module tb_delay_index_controller;

  localparam int NS = 6;
  localparam int IW = 4;
  localparam int SW = 3;
`ifdef CFG_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int FL = SW + IW + PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ws;
  logic          cfg_frame;
  logic          cfg_bit_valid;
  logic          cfg_bit;
  logic [NS*IW-1:0] delay_index;
  logic          cfg_busy;
  logic          cfg_error;
  logic          commit;

  int errors = 0;
  int checks = 0;

  int m_shadow [NS];
  int m_active [NS];
  bit m_pending;

  delay_index_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ws            (ws),
    .cfg_frame     (cfg_frame),
    .cfg_bit_valid (cfg_bit_valid),
    .cfg_bit       (cfg_bit),
    .delay_index   (delay_index),
    .cfg_busy      (cfg_busy),
    .cfg_error     (cfg_error),
    .commit        (commit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_index();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) begin
      v[k*IW +: IW] = IW'(m_active[k]);
    end
    return v;
  endfunction

  function automatic logic [15:0] mk(input int sel, input int idx);
    logic [15:0] w;
    w = 16'((sel << IW) | idx);
    if (PW != 0) begin
      w = (w << 1) | 16'(^w);
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    m_pending = 1'b0;
  endtask

  task automatic model_fall(output bit committed);
    committed = m_pending;
    if (m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
  endtask

  // Sends n bits of word (MSB first) as one frame; optionally drops ws during WRITE.
  task automatic send_frame(input logic [15:0] word, input int n, input bit fall_in_write);
    int sel;
    int idx;
    bit ok;
    bit exp_c;
    sel = int'((word >> (IW + PW)) & 16'h7);
    idx = int'((word >> PW) & 16'hF);
    ok  = (n == FL) && (sel < NS);
    if (PW != 0) begin
      logic [15:0] masked;
      masked = word & 16'((1 << FL) - 1);
      ok = ok && !(^masked);
    end
    @(negedge clk);
    cfg_frame     = 1'b1;
    cfg_bit_valid = 1'b1;
    cfg_bit       = word[n-1];
    for (int i = n - 2; i >= 0; i--) begin
      @(negedge clk);
      cfg_bit_valid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      cfg_bit_valid = 1'b1;
      cfg_bit       = word[i];
    end
    @(negedge clk);
    cfg_frame     = 1'b0;
    cfg_bit_valid = 1'b0;
    @(negedge clk);
    check("busy_in_write", cfg_busy, 1);
    check("error_in_write", cfg_error, !ok);
    if (fall_in_write) ws = 1'b0;
    @(negedge clk);
    exp_c = 1'b0;
    if (fall_in_write) model_fall(exp_c);
    if (ok) begin
      m_shadow[sel] = idx;
      m_pending     = 1'b1;
    end
    check("error_after_write", cfg_error, 0);
    check("commit_after_write", commit, exp_c);
    check("index_after_write", delay_index, model_index());
    check("busy_after_write", cfg_busy, m_pending);
    ws = 1'b1;
  endtask

  task automatic ws_fall();
    bit exp_c;
    @(negedge clk);
    check("commit_quiet", commit, 0);
    ws = 1'b0;
    @(negedge clk);
    model_fall(exp_c);
    check("commit_on_fall", commit, exp_c);
    check("index_on_fall", delay_index, model_index());
    check("busy_on_fall", cfg_busy, m_pending);
    ws = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    ws            = 1'b1;
    cfg_frame     = 1'b0;
    cfg_bit_valid = 1'b0;
    cfg_bit       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_index", delay_index, 0);
    check("reset_busy", cfg_busy, 0);
    check("reset_error", cfg_error, 0);
    check("reset_commit", commit, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(mk(2, 10), FL, 1'b0);
    ws_fall();
    send_frame(16'h2B, FL - 1, 1'b0);
    ws_fall();
    send_frame(mk(7, 6), FL, 1'b0);
    ws_fall();
    send_frame(mk(0, 3), FL, 1'b0);
    send_frame(mk(0, 5), FL, 1'b0);
    ws_fall();
    send_frame(mk(4, 9), FL, 1'b0);
    send_frame(mk(4, 2), FL, 1'b1);
    ws_fall();

    begin
      logic [15:0] w;
      w = mk(3, 12);
      @(negedge clk);
      cfg_frame     = 1'b1;
      cfg_bit_valid = 1'b1;
      for (int i = FL - 1; i > FL - 5; i--) begin
        cfg_bit = w[i];
        @(negedge clk);
      end
      rst_n         = 1'b0;
      cfg_frame     = 1'b0;
      cfg_bit_valid = 1'b0;
      #1;
      model_reset();
      check("midreset_index", delay_index, 0);
      check("midreset_busy", cfg_busy, 0);
      check("midreset_error", cfg_error, 0);
      check("midreset_commit", commit, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    send_frame(mk(1, 15), FL, 1'b0);
    ws_fall();

`ifdef CFG_PARITY_EN
    send_frame(mk(5, 7) ^ 16'h1, FL, 1'b0);
    ws_fall();
`endif

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        ws_fall();
      end else begin
        int sel;
        int idx;
        int mode;
        bit fall;
        sel  = $urandom_range(0, 7);
        idx  = $urandom_range(0, 15);
        mode = $urandom_range(0, 5);
        fall = ($urandom_range(0, 3) == 0);
        if (mode == 0)      send_frame(16'($urandom), FL - 1, fall);
        else if (mode == 1) send_frame(16'($urandom), FL + 1, fall);
        else                send_frame(mk(sel, idx), FL, fall);
      end
    end
    ws_fall();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
